// File: rtl/ahb_sram_slave_if.sv
// Purpose: AHB-Lite bus bundle between one initiator and the on-chip SRAM responder.
// Latency: none, this is only wiring.
// Backpressure: the responder stalls the initiator by holding oHREADY low; the initiator then holds its address phase.
//   Initiator -> responder: iHSEL, iHADDR, iHTRANS, iHWRITE, iHSIZE, iHBURST, iHWDATA
//   Responder -> initiator: oHRDATA, oHREADY, oHRESP
interface ahb_sram_slave_if;
    logic        iHSEL;
    logic [31:0] iHADDR;
    logic [1:0]  iHTRANS;
    logic        iHWRITE;
    logic [2:0]  iHSIZE;
    logic [2:0]  iHBURST;
    logic [31:0] iHWDATA;
    logic [31:0] oHRDATA;
    logic        oHREADY;
    logic [1:0]  oHRESP;

    modport master (
        output iHSEL, iHADDR, iHTRANS, iHWRITE, iHSIZE, iHBURST, iHWDATA,
        input  oHRDATA, oHREADY, oHRESP
    );

    modport slave (
        input  iHSEL, iHADDR, iHTRANS, iHWRITE, iHSIZE, iHBURST, iHWDATA,
        output oHRDATA, oHREADY, oHRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// Purpose: AHB-Lite responder mapping a 2^MEM_AW x 32-bit word SRAM at BASE_ADDR.
// Latency: writes complete with zero wait; reads insert RD_WAIT wait states; illegal transfers get a 2-cycle ERROR.
// Backpressure: oHREADY is low during read wait states and the first ERROR cycle; no address phase is sampled then.
//   Ports: iHCLK (bus clock), iHRESETn (async active-low reset), bus (slave modport of ahb_sram_slave_if).
//   Memory contents are not reset; only the control state, registered index/lanes and read-data hold are.
module ahb_sram_slave #(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          RD_WAIT   = 1
) (
    input  logic              iHCLK,
    input  logic              iHRESETn,
    ahb_sram_slave_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        RWAIT,
        RDATA,
        ERR1,
        ERR2
    } state_t;

    // Wait counter counts down from RD_WAIT-1 to 0 while in RWAIT.
    localparam logic [1:0] WAIT_INIT = (RD_WAIT > 0) ? 2'(RD_WAIT - 1) : 2'd0;

    state_t              state, state_d;
    logic [1:0]          wait_cnt, wait_cnt_d;
    logic [MEM_AW-1:0]   idx_q;
    logic [3:0]          be_q;
    logic [31:0]         rdata_q;
    logic [31:0]         mem [0:(2**MEM_AW)-1];

    logic                hready;
    logic                accept;
    logic                in_range;
    logic                aligned;
    logic                legal;
    logic [3:0]          be_d;
    logic [31:0]         mem_rd;

    // iHBURST is ignored (every beat stands alone) and only iHTRANS[1] decides
    // whether a transfer is present; fold the unused bits away here.
    logic                unused_bits;
    assign unused_bits = ^{bus.iHBURST, bus.iHTRANS[0]};

    assign hready = (state != RWAIT) && (state != ERR1);
    assign accept = bus.iHSEL && bus.iHTRANS[1] && hready;

    // BASE_ADDR is aligned to the window size, so the range test reduces to
    // matching the address bits above the word index.
    assign in_range = (bus.iHADDR[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);

    always_comb begin
        aligned = 1'b0;
        be_d    = 4'b0000;
        case (bus.iHSIZE)
            3'b000: begin
                aligned = 1'b1;
                be_d    = 4'b0001 << bus.iHADDR[1:0];
            end
            3'b001: begin
                aligned = ~bus.iHADDR[0];
                be_d    = bus.iHADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                aligned = (bus.iHADDR[1:0] == 2'b00);
                be_d    = 4'b1111;
            end
            default: begin
                aligned = 1'b0;
                be_d    = 4'b0000;
            end
        endcase
    end

    assign legal = in_range && aligned;

    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        case (state)
            IDLE, WDATA, RDATA, ERR2: begin
                // Every ready-high state doubles as an address phase, which
                // is what lets pipelined transfers run back to back.
                state_d = IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_d = ERR1;
                    end else if (bus.iHWRITE) begin
                        state_d = WDATA;
                    end else if (RD_WAIT > 0) begin
                        state_d    = RWAIT;
                        wait_cnt_d = WAIT_INIT;
                    end else begin
                        state_d = RDATA;
                    end
                end
            end
            RWAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_d = RDATA;
                end else begin
                    wait_cnt_d = wait_cnt - 2'd1;
                end
            end
            ERR1: begin
                state_d = ERR2;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iHCLK or negedge iHRESETn) begin
        if (!iHRESETn) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
            idx_q    <= '0;
            be_q     <= 4'b0000;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            if (accept && legal) begin
                idx_q <= bus.iHADDR[MEM_AW+1:2];
                be_q  <= be_d;
            end
        end
    end

    // Asynchronous reset forces state to IDLE at once, so a write whose
    // WDATA cycle is cut short by reset never reaches the array.
    always_ff @(posedge iHCLK) begin
        if (state == WDATA) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= bus.iHWDATA[8*b +: 8];
                end
            end
        end
    end

    // The index is registered and the array read is combinational, so a read
    // accepted during a write's WDATA cycle sees the word written at that edge.
    assign mem_rd = mem[idx_q];

    always_ff @(posedge iHCLK or negedge iHRESETn) begin
        if (!iHRESETn) begin
            rdata_q <= 32'h0;
        end else if (state == RDATA) begin
            rdata_q <= mem_rd;
        end
    end

    assign bus.oHREADY = hready;
    assign bus.oHRESP  = ((state == ERR1) || (state == ERR2)) ? 2'b01 : 2'b00;
    assign bus.oHRDATA = (state == RDATA) ? mem_rd : rdata_q;

endmodule
